// File: rtl/memory_col_ctrl.sv
// rtl/memory_col_ctrl.sv - two-requester column controller with clear sequencer
//
// Purpose: owns one 1024 x 8 memory column. After reset, or on a clr_start request,
// it zeroes all 1024 words, one per cycle. Otherwise it arbitrates between
// requesters A and B, issuing at most one command per cycle. Ties are broken
// round-robin. Each read returns data one cycle after it is accepted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   clr_start                  re-clear request (honoured in RUN only)
//   init_busy                  high while the clear sequence runs
//   a_/b_valid, a_/b_ready     command handshake (ready == grant)
//   a_/b_we, a_/b_addr, a_/b_wdata   command fields
//   a_/b_rsp_valid, a_/b_rsp_data    read response, data zero when not valid
//   mem_addr, mem_wr_data, mem_byte_en  column command
//   mem_rd_data                column read data, one cycle after its address
module memory_col_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_start,
  output logic       init_busy,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic       a_we,
  input  logic [9:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_rsp_valid,
  output logic [7:0] a_rsp_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic       b_we,
  input  logic [9:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_rsp_valid,
  output logic [7:0] b_rsp_data,
  output logic [9:0] mem_addr,
  output logic [7:0] mem_wr_data,
  output logic       mem_byte_en,
  input  logic [7:0] mem_rd_data
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  // 1 = B was granted most recently; reset value lets A win the first tie.
  logic       last_b_q, last_b_d;
  // One-deep response pipeline: marks that the column read issued last cycle
  // belongs to this port.
  logic       rsp_a_q, rsp_a_d;
  logic       rsp_b_q, rsp_b_d;
  logic       grant_a, grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= 10'd0;
      last_b_q <= 1'b1;
      rsp_a_q  <= 1'b0;
      rsp_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      rsp_a_q  <= rsp_a_d;
      rsp_b_q  <= rsp_b_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_b_d    = last_b_q;
    rsp_a_d     = 1'b0;
    rsp_b_d     = 1'b0;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    init_busy   = 1'b0;
    mem_addr    = 10'd0;
    mem_wr_data = 8'h00;
    mem_byte_en = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        init_busy   = 1'b1;
        mem_addr    = cnt_q;
        mem_byte_en = 1'b1;
        // The counter wraps naturally from 1023 to 0 as RUN is entered.
        cnt_d       = cnt_q + 10'd1;
        if (cnt_q == 10'd1023) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        grant_a = a_valid && (!b_valid || last_b_q);
        grant_b = b_valid && !grant_a;
        if (grant_a) begin
          mem_addr    = a_addr;
          mem_wr_data = a_wdata;
          mem_byte_en = a_we;
          last_b_d    = 1'b0;
          rsp_a_d     = !a_we;
        end else if (grant_b) begin
          mem_addr    = b_addr;
          mem_wr_data = b_wdata;
          mem_byte_en = b_we;
          last_b_d    = 1'b1;
          rsp_b_d     = !b_we;
        end
        // A read granted alongside clr_start still completes: its response
        // pipeline entry is kept while the clear begins.
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = 10'd0;
        end
      end
    endcase
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign a_rsp_valid = rsp_a_q;
  assign b_rsp_valid = rsp_b_q;
  assign a_rsp_data  = rsp_a_q ? mem_rd_data : 8'h00;
  assign b_rsp_data  = rsp_b_q ? mem_rd_data : 8'h00;

endmodule

// File: tb/tb_memory_col_ctrl.sv
// tb/tb_memory_col_ctrl.sv - self-checking bench for memory_col_ctrl
module tb_memory_col_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_start;
  logic       init_busy;
  logic       a_valid, a_ready, a_we, a_rsp_valid;
  logic [9:0] a_addr;
  logic [7:0] a_wdata, a_rsp_data;
  logic       b_valid, b_ready, b_we, b_rsp_valid;
  logic [9:0] b_addr;
  logic [7:0] b_wdata, b_rsp_data;
  logic [9:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic       mem_byte_en;
  logic [7:0] mem_rd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_col_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .init_busy(init_busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en),
    .mem_rd_data(mem_rd_data)
  );

  // Memory column: registered read returning the pre-write value.
  logic [7:0] col [1024];
  logic       col_seeded = 1'b0;
  always @(posedge clk) begin
    if (!col_seeded) begin
      for (int i = 0; i < 1024; i++) col[i] <= 8'($urandom);
      col_seeded <= 1'b1;
    end else begin
      if (mem_byte_en) col[mem_addr] <= mem_wr_data;
      mem_rd_data <= col[mem_addr];
    end
  end

  // Reference model state.
  bit         m_clearing;
  int         m_cnt;
  bit         m_last_b;
  bit         m_pa, m_pb;
  logic [7:0] m_pad, m_pbd;
  logic [7:0] sh [1024];

  // Observations from the latest cycle, for scenario-level checks.
  bit         o_ar, o_br, o_arv, o_brv, o_busy;
  logic [7:0] o_ard, o_brd;

  task automatic step(input bit av, input bit awe, input logic [9:0] aa, input logic [7:0] ad,
                      input bit bv, input bit bwe, input logic [9:0] ba, input logic [7:0] bd,
                      input bit clr);
    bit ga, gb, e_be;
    logic [9:0] e_addr;
    logic [7:0] e_wd;
    a_valid = av; a_we = av ? awe : 1'($urandom);
    a_addr = av ? aa : 10'($urandom); a_wdata = av ? ad : 8'($urandom);
    b_valid = bv; b_we = bv ? bwe : 1'($urandom);
    b_addr = bv ? ba : 10'($urandom); b_wdata = bv ? bd : 8'($urandom);
    clr_start = clr;
    #1;
    ga = 1'b0; gb = 1'b0; e_addr = 10'd0; e_wd = 8'h00; e_be = 1'b0;
    if (m_clearing) begin
      e_addr = m_cnt[9:0]; e_be = 1'b1;
    end else begin
      if (av && bv) begin
        ga = m_last_b; gb = !m_last_b;
      end else begin
        ga = av; gb = bv;
      end
      if (ga) begin e_addr = aa; e_wd = ad; e_be = awe; end
      if (gb) begin e_addr = ba; e_wd = bd; e_be = bwe; end
    end
    tests++; if (init_busy !== m_clearing) begin fails++; $display("FAIL init_busy t=%0t got %b exp %b", $time, init_busy, m_clearing); end
    tests++; if (a_ready !== ga) begin fails++; $display("FAIL a_ready t=%0t got %b exp %b", $time, a_ready, ga); end
    tests++; if (b_ready !== gb) begin fails++; $display("FAIL b_ready t=%0t got %b exp %b", $time, b_ready, gb); end
    tests++; if (mem_addr !== e_addr) begin fails++; $display("FAIL mem_addr t=%0t got %0d exp %0d", $time, mem_addr, e_addr); end
    tests++; if (mem_wr_data !== e_wd) begin fails++; $display("FAIL mem_wr_data t=%0t got %h exp %h", $time, mem_wr_data, e_wd); end
    tests++; if (mem_byte_en !== e_be) begin fails++; $display("FAIL mem_byte_en t=%0t got %b exp %b", $time, mem_byte_en, e_be); end
    tests++; if (a_rsp_valid !== m_pa) begin fails++; $display("FAIL a_rsp_valid t=%0t got %b exp %b", $time, a_rsp_valid, m_pa); end
    tests++; if (a_rsp_data !== (m_pa ? m_pad : 8'h00)) begin fails++; $display("FAIL a_rsp_data t=%0t got %h exp %h", $time, a_rsp_data, m_pa ? m_pad : 8'h00); end
    tests++; if (b_rsp_valid !== m_pb) begin fails++; $display("FAIL b_rsp_valid t=%0t got %b exp %b", $time, b_rsp_valid, m_pb); end
    tests++; if (b_rsp_data !== (m_pb ? m_pbd : 8'h00)) begin fails++; $display("FAIL b_rsp_data t=%0t got %h exp %h", $time, b_rsp_data, m_pb ? m_pbd : 8'h00); end
    o_ar = a_ready; o_br = b_ready; o_arv = a_rsp_valid; o_brv = b_rsp_valid;
    o_ard = a_rsp_data; o_brd = b_rsp_data; o_busy = init_busy;
    // Advance the model by one cycle.
    m_pa = ga && !awe; m_pad = sh[aa];
    m_pb = gb && !bwe; m_pbd = sh[ba];
    if (ga && awe) sh[aa] = ad;
    if (gb && bwe) sh[ba] = bd;
    if (ga) m_last_b = 1'b0;
    if (gb) m_last_b = 1'b1;
    if (m_clearing) begin
      sh[m_cnt] = 8'h00;
      m_cnt = m_cnt + 1;
      if (m_cnt == 1024) begin m_clearing = 1'b0; m_cnt = 0; end
    end else if (clr) begin
      m_clearing = 1'b1; m_cnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 10'd0, 8'h00, 0, 0, 10'd0, 8'h00, 0);
  endtask

  // Asserts reset mid-cycle, checks the forced outputs, releases on a negedge.
  task automatic apply_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL rst_init_busy got %b exp 1", init_busy); end
    tests++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b%b exp 00", a_ready, b_ready); end
    tests++; if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %b%b exp 00", a_rsp_valid, b_rsp_valid); end
    tests++; if (a_rsp_data !== 8'h00 || b_rsp_data !== 8'h00) begin fails++; $display("FAIL rst_rsp_data got %h %h exp 00 00", a_rsp_data, b_rsp_data); end
    tests++; if (mem_byte_en !== 1'b1 || mem_addr !== 10'd0 || mem_wr_data !== 8'h00) begin
      fails++; $display("FAIL rst_mem got en=%b addr=%0d wd=%h exp en=1 addr=0 wd=00", mem_byte_en, mem_addr, mem_wr_data);
    end
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    m_clearing = 1'b1; m_cnt = 0; m_last_b = 1'b1; m_pa = 1'b0; m_pb = 1'b0;
    sh[0] = 8'h00;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_we = 1'b0; b_we = 1'b0;
    apply_reset(2);
  endtask

  task automatic test_initial_clear();
    int busy_cycles = 0;
    for (int i = 0; i < 1024; i++) begin
      idle();
      if (o_busy) busy_cycles++;
    end
    tests++; if (busy_cycles !== 1024) begin fails++; $display("FAIL clear_len got %0d exp 1024", busy_cycles); end
    // First run cycle: a tie goes to A.
    step(1, 0, 10'd5, 8'h00, 1, 0, 10'd6, 8'h00, 0);
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL busy_after_clear got %b exp 0", o_busy); end
    tests++; if (o_ar !== 1'b1 || o_br !== 1'b0) begin fails++; $display("FAIL first_tie got a=%b b=%b exp a=1 b=0", o_ar, o_br); end
    step(0, 0, 10'd0, 8'h00, 1, 0, 10'd6, 8'h00, 0);
    tests++; if (o_arv !== 1'b1 || o_ard !== 8'h00) begin fails++; $display("FAIL read5 got v=%b d=%h exp v=1 d=00", o_arv, o_ard); end
    idle();
    tests++; if (o_brv !== 1'b1 || o_brd !== 8'h00) begin fails++; $display("FAIL read6 got v=%b d=%h exp v=1 d=00", o_brv, o_brd); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 10'(20 + i), 8'h00, 1, 0, 10'(30 + i), 8'h00, 0);
      tests++; if (o_ar !== (i % 2 == 0) || o_br !== (i % 2 == 1)) begin
        fails++; $display("FAIL rr_grant%0d got a=%b b=%b exp a=%b", i, o_ar, o_br, (i % 2 == 0));
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    step(1, 1, 10'd10, 8'hA5, 0, 0, 10'd0, 8'h00, 0);
    step(1, 0, 10'd10, 8'h00, 0, 0, 10'd0, 8'h00, 0);
    idle();
    tests++; if (o_arv !== 1'b1 || o_ard !== 8'hA5 || o_brv !== 1'b0) begin
      fails++; $display("FAIL wr_rd got av=%b ad=%h bv=%b exp av=1 ad=a5 bv=0", o_arv, o_ard, o_brv);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) step(1, 1, 10'(i), vals[i], 0, 0, 10'd0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(0, 0, 10'd0, 8'h00, 1, 0, 10'(i), 8'h00, 0);
      else idle();
      if (i < 4) begin
        tests++; if (o_br !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got %b exp 1", i, o_br); end
      end
      if (i > 0) begin
        tests++; if (o_brv !== 1'b1 || o_brd !== vals[i-1]) begin
          fails++; $display("FAIL b2b_rsp%0d got v=%b d=%h exp v=1 d=%h", i, o_brv, o_brd, vals[i-1]);
        end
      end
    end
  endtask

  task automatic test_clr_start();
    step(1, 0, 10'd10, 8'h00, 0, 0, 10'd0, 8'h00, 1);
    tests++; if (o_ar !== 1'b1) begin fails++; $display("FAIL clr_grant got %b exp 1", o_ar); end
    idle();
    tests++; if (o_arv !== 1'b1 || o_ard !== 8'hA5 || o_busy !== 1'b1) begin
      fails++; $display("FAIL clr_rsp got v=%b d=%h busy=%b exp v=1 d=a5 busy=1", o_arv, o_ard, o_busy);
    end
    // clr_start is ignored while the clear runs.
    for (int i = 1; i < 1024; i++) step(0, 0, 10'd0, 8'h00, 0, 0, 10'd0, 8'h00, (i == 500));
    step(1, 0, 10'd10, 8'h00, 0, 0, 10'd0, 8'h00, 0);
    tests++; if (o_busy !== 1'b0 || o_ar !== 1'b1) begin fails++; $display("FAIL clr_done got busy=%b ar=%b exp 0 1", o_busy, o_ar); end
    idle();
    tests++; if (o_arv !== 1'b1 || o_ard !== 8'h00) begin fails++; $display("FAIL clr_data got v=%b d=%h exp v=1 d=00", o_arv, o_ard); end
  endtask

  task automatic test_reset_mid_run();
    step(1, 1, 10'd3, 8'h5C, 0, 0, 10'd0, 8'h00, 0);
    step(1, 0, 10'd3, 8'h00, 0, 0, 10'd0, 8'h00, 0);
    #1;
    tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h5C) begin
      fails++; $display("FAIL pre_rst_rsp got v=%b d=%h exp v=1 d=5c", a_rsp_valid, a_rsp_data);
    end
    apply_reset(3);
  endtask

  task automatic test_reset_mid_clear();
    int waited = 0;
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) step(1, 0, 10'd7, 8'h00, 0, 0, 10'd0, 8'h00, 0);
    apply_reset(3);
    for (int i = 0; i < 1100 && !got; i++) begin
      step(1, 0, 10'd7, 8'h00, 0, 0, 10'd0, 8'h00, 0);
      if (o_ar) got = 1'b1; else waited++;
    end
    tests++; if (!got || waited !== 1024) begin fails++; $display("FAIL rst_clear_wait got granted=%b after %0d exp 1024", got, waited); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), 10'($urandom % 16), 8'($urandom),
           ($urandom % 4) != 0, 1'($urandom), 10'($urandom % 16), 8'($urandom), 0);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1; clr_start = 1'b0;
    a_valid = 1'b0; a_we = 1'b0; a_addr = 10'd0; a_wdata = 8'h00;
    b_valid = 1'b0; b_we = 1'b0; b_addr = 10'd0; b_wdata = 8'h00;
    @(negedge clk);
    test_reset();
    test_initial_clear();
    test_round_robin();
    test_write_read();
    test_back_to_back();
    test_clr_start();
    test_reset_mid_run();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
